// File: rtl/fxp_div_seq.sv
// -----------------------------------------------------------------------------
// fxp_div_seq
//
// Sequential signed fixed-point divider with saturation. Computes P = A / B in
// a shared QX.F format (WIDTH total bits, FRAC fractional bits). It uses a
// restoring algorithm on magnitudes and produces one quotient bit per cycle.
// The ideal quotient (A << FRAC) / B is truncated toward zero. It is then
// saturated to the WIDTH-bit signed range.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request; sampled only while busy=0
//   A      in   WIDTH-bit signed dividend (QX.F)
//   B      in   WIDTH-bit signed divisor (QX.F)
//   busy   out  high while a division is in progress
//   done   out  one-cycle pulse when P/OV/DZ update
//   P      out  WIDTH-bit signed saturated quotient (registered)
//   OV     out  result saturated (includes divide-by-zero)
//   DZ     out  divisor was zero
//
// Timing: start is accepted at edge k. CALC runs on edges k+1..k+N, where
// N = WIDTH+FRAC. FIX registers the result at edge k+N+1, so done is high in
// the following cycle.
// -----------------------------------------------------------------------------
module fxp_div_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned FRAC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] P,
  output logic             OV,
  output logic             DZ
);

  localparam int unsigned N    = WIDTH + FRAC;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RemW = WIDTH + 1;

  localparam logic [WIDTH-1:0] PMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] PMin = {1'b1, {(WIDTH-1){1'b0}}};
  // Largest quotient magnitudes that fit without saturation, per sign.
  localparam logic [N-1:0]     QPosMax = N'(PMax);
  localparam logic [N-1:0]     QNegMax = N'(PMin);
  localparam logic [CntW-1:0]  CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } state_e;

  state_e state_q, state_d;

  logic [N-1:0]      dvd_q, dvd_d;     // dividend magnitude, consumed MSB first
  logic [WIDTH-1:0]  div_q, div_d;     // divisor magnitude
  logic [RemW-1:0]   rem_q, rem_d;     // partial remainder
  logic [N-1:0]      quo_q, quo_d;     // quotient magnitude
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              dzp_q, dzp_d;     // divide-by-zero pending for this op
  logic              aneg_q, aneg_d;   // sign of A, selects the DZ saturation
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  p_q, p_d;
  logic              ov_q, ov_d;
  logic              dz_q, dz_d;

  // Input magnitudes. Negating the most negative value yields 2^(WIDTH-1),
  // which is still correct when read as unsigned.
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // One restoring step.
  logic [RemW:0]    rem_shift;
  logic [RemW:0]    div_ext;
  logic             q_bit;

  always_comb begin
    a_mag = A[WIDTH-1] ? -A : A;
    b_mag = B[WIDTH-1] ? -B : B;
  end

  always_comb begin
    rem_shift = {rem_q, dvd_q[N-1]};
    div_ext   = {2'b00, div_q};
    q_bit     = (rem_shift >= div_ext);
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    dzp_d   = dzp_q;
    aneg_d  = aneg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    p_d     = p_q;
    ov_d    = ov_q;
    dz_d    = dz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d   = N'(a_mag) << FRAC;
          div_d   = b_mag;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          neg_d   = A[WIDTH-1] ^ B[WIDTH-1];
          dzp_d   = (B == '0);
          aneg_d  = A[WIDTH-1];
          busy_d  = 1'b1;
          state_d = StCalc;
        end
      end

      StCalc: begin
        rem_d = q_bit ? RemW'(rem_shift - div_ext) : RemW'(rem_shift);
        quo_d = (quo_q << 1) | N'(q_bit);
        dvd_d = dvd_q << 1;
        if (cnt_q == CntLast) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StFix: begin
        dz_d = dzp_q;
        if (dzp_q) begin
          p_d  = aneg_q ? PMin : PMax;
          ov_d = 1'b1;
        end else if (!neg_q && (quo_q > QPosMax)) begin
          p_d  = PMax;
          ov_d = 1'b1;
        end else if (neg_q && (quo_q > QNegMax)) begin
          p_d  = PMin;
          ov_d = 1'b1;
        end else begin
          // A zero magnitude negates to zero, so the result is never -0.
          p_d  = neg_q ? -quo_q[WIDTH-1:0] : quo_q[WIDTH-1:0];
          ov_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      dzp_q   <= 1'b0;
      aneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
      ov_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      dzp_q   <= dzp_d;
      aneg_q  <= aneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
      ov_q    <= ov_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;
  assign OV   = ov_q;
  assign DZ   = dz_q;

endmodule

// File: tb/tb_fxp_div_seq.sv
module tb_fxp_div_seq;

  localparam int W = 4;
  localparam int F = 2;
  localparam int Lat = W + F + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] p;
  logic         ov;
  logic         dz;

  int checks = 0;
  int errors = 0;

  fxp_div_seq #(.WIDTH(W), .FRAC(F)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .busy  (busy),
    .done  (done),
    .P     (p),
    .OV    (ov),
    .DZ    (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain signed integer division (which truncates toward
  // zero), followed by clamping to the W-bit signed range.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] ep, output logic eov,
                                  output logic edz);
    int sa;
    int sb;
    int q;
    int qmax;
    int qmin;
    sa   = $signed(a);
    sb   = $signed(b);
    qmax = (1 << (W - 1)) - 1;
    qmin = -(1 << (W - 1));
    if (sb == 0) begin
      edz = 1'b1;
      eov = 1'b1;
      q   = (sa >= 0) ? qmax : qmin;
    end else begin
      edz = 1'b0;
      q   = (sa * (1 << F)) / sb;
      eov = 1'b0;
      if (q > qmax) begin
        q   = qmax;
        eov = 1'b1;
      end else if (q < qmin) begin
        q   = qmin;
        eov = 1'b1;
      end
    end
    ep = W'(q);
  endfunction

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag,
                         input bit disturb);
    logic [W-1:0] ep;
    logic         eov;
    logic         edz;
    int           lat;
    bit           busy_ok;
    ref_div(a, b, ep, eov, edz);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    busy_ok = busy;
    lat     = 0;
    while (lat < 20) begin
      @(negedge clk);
      // Inputs change after acceptance; an extra start mid-run must be ignored.
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      start = disturb && (lat == 1);
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      busy_ok = busy_ok && busy;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, ".lat"}, lat, Lat);
    check({tag, ".busy_run"}, {31'd0, busy_ok}, 32'd1);
    check({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, ".P"}, {28'd0, p}, {28'd0, ep});
    check({tag, ".OV"}, {31'd0, ov}, {31'd0, eov});
    check({tag, ".DZ"}, {31'd0, dz}, {31'd0, edz});
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int ndone;
    int prev;
    bit saw_done;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #12;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.P", {28'd0, p}, 32'd0);
    check("rst.OV", {31'd0, ov}, 32'd0);
    check("rst.DZ", {31'd0, dz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(4'b0110, 4'b0100, "d_1p5_1p0", 1'b0);
    run_div(4'd6, 4'd2, "d_sat_pos", 1'b0);
    run_div(4'b1000, 4'b1100, "d_m8_m4", 1'b0);
    run_div(4'b1000, 4'b0100, "d_m8_4", 1'b0);
    run_div(4'd1, 4'd3, "d_trunc_p", 1'b0);
    run_div(4'b1111, 4'd3, "d_trunc_n", 1'b0);
    run_div(4'd1, 4'b1000, "d_zero_neg", 1'b0);
    run_div(4'd3, 4'd0, "d_dz_pos", 1'b0);
    run_div(4'b1101, 4'd0, "d_dz_neg", 1'b0);
    run_div(4'd0, 4'd0, "d_dz_zero", 1'b0);
    run_div(4'd5, 4'd7, "d_disturb", 1'b1);

    // Start held high: back-to-back results every Lat+1 cycles.
    @(negedge clk);
    a_in  = 4'b0110;
    b_in  = 4'b0100;
    start = 1'b1;
    cyc   = 0;
    ndone = 0;
    prev  = 0;
    while (ndone < 3 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        ndone++;
        if (ndone == 1) check("b2b.first", cyc, Lat + 1);
        else            check("b2b.gap", cyc - prev, Lat + 1);
        check("b2b.P", {28'd0, p}, 32'd6);
        prev = cyc;
      end
    end
    check("b2b.count", ndone, 3);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);

    // Asynchronous reset during CALC, after a result with all flags set.
    run_div(4'd3, 4'd0, "pre_rst", 1'b0);
    @(negedge clk);
    a_in  = 4'd3;
    b_in  = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst.busy", {31'd0, busy}, 32'd0);
    check("arst.done", {31'd0, done}, 32'd0);
    check("arst.P", {28'd0, p}, 32'd0);
    check("arst.OV", {31'd0, ov}, 32'd0);
    check("arst.DZ", {31'd0, dz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      saw_done = saw_done || done;
    end
    check("arst.no_done", {31'd0, saw_done}, 32'd0);
    run_div(4'd1, 4'd3, "post_rst", 1'b0);

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_div(W'(ia), W'(ib), $sformatf("sweep_%0d_%0d", ia, ib), ($urandom % 4) == 0);
      end
    end

    for (int i = 0; i < 40; i++) begin
      run_div(W'($urandom), W'($urandom), $sformatf("rand_%0d", i), ($urandom % 2) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fxp_div_seq.md
Name: fxp_div_seq

Overview:
- Sequential signed fixed-point divider with saturation. It is the inverse of the team's saturating QX.F multiplier.
- Computes P = A / B in the same QX.F format, with OV and divide-by-zero flags.
- Used in the IIR test environment to recover/normalise coefficients and to check multiplier results (A*B/B).
- Uses a start/busy/done handshake and a restoring algorithm at one quotient bit per cycle.

Parameters:
- WIDTH, 4: total bits of A, B and P (two's complement).
- FRAC, 2: fractional bits. Default Q1.2, matching the multiplier. Constraint: 0 <= FRAC < WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request. Sampled only when busy=0.
- A  in  WIDTH  signed dividend, QX.F.
- B  in  WIDTH  signed divisor, QX.F.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse when P/OV/DZ update.
- P  out  WIDTH  signed quotient, QX.F, saturated. Registered.
- OV  out  1  high if the result saturated, including divide-by-zero.
- DZ  out  1  high if B was 0.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, P=0, OV=0, DZ=0; all internal registers cleared. Reset mid-operation aborts the division; no done pulse is produced for it.
- Arithmetic: ideal Q = (A << FRAC) / B, truncated toward zero.
  - Computed on magnitudes: |A| is WIDTH bits unsigned, so |-2^(WIDTH-1)| = 2^(WIDTH-1) is valid.
  - Dividend magnitude is WIDTH+FRAC bits; quotient magnitude is WIDTH+FRAC bits; remainder register is WIDTH+1 bits.
  - neg = sign(A) XOR sign(B). A zero quotient is never negative.
- Saturation:
  - If neg=0 and |Q| > 2^(WIDTH-1)-1: P = 2^(WIDTH-1)-1, OV=1.
  - If neg=1 and |Q| > 2^(WIDTH-1): P = -2^(WIDTH-1), OV=1.
  - Otherwise P = +/-|Q| and OV=0.
- Divide-by-zero (B=0): DZ=1, OV=1. P = max positive if A >= 0, else P = min negative. Latency is unchanged.
- FSM states:
  - IDLE: busy=0. On start=1 at edge k, latch |A|<<FRAC, |B|, neg, dz and the sign of A. Clear the remainder and counter. Go to CALC; busy=1 from edge k.
  - CALC: N = WIDTH+FRAC cycles. Each cycle: shift the next dividend MSB into the remainder. If remainder >= |B|, subtract and set the quotient bit to 1, else 0. After the N-th iteration go to FIX.
  - FIX (one cycle): apply sign, saturation and dz. Register P/OV/DZ, pulse done=1, set busy=0, return to IDLE.
- Latency:
  - done is high in the cycle after edge k+N+1: 7 cycles for the defaults.
  - Latency is constant for all operands, including B=0.
  - Throughput is one result per N+2 cycles at best. A new start is accepted in the cycle done is high, because the FSM is already in IDLE.
- Handshake rules:
  - start while busy=1 is ignored; no queueing.
  - A/B are sampled only on the accepting edge, so later changes have no effect.
- P, OV and DZ hold their values until the next done.
- done is never high for more than one consecutive cycle unless back-to-back starts occur.

Test Plan:
- Reset, then start with A=4'b0110 (1.5), B=4'b0100 (1.0) -> done exactly 7 cycles after start; P=4'b0110, OV=0, DZ=0; busy high for those cycles.
- A=6 (1.5), B=2 (0.5) -> P=7 (1.75), OV=1. A=-8, B=-4 -> P=7, OV=1. A=-8, B=4 -> P=-8, OV=0.
- Truncation toward zero: A=1, B=3 -> P=1. A=-1, B=3 -> P=-1. A=1, B=-8 -> P=0, and the result is not negative.
- Divide-by-zero: A=3, B=0 -> P=7, OV=1, DZ=1. A=-3, B=0 -> P=-8, OV=1, DZ=1. A=0, B=0 -> P=7. Latency is 7 in every case.
- Start pulsed again mid-operation with different A/B -> ignored; the first result is returned. Start held high -> back-to-back results, with done every 8 cycles.
- Assert rst during CALC -> all outputs 0 immediately (asynchronously); no done pulse. The next start gives a correct result.
- Exhaustive sweep of all 256 A/B pairs -> P/OV/DZ match the reference model.
